// File: rtl/axilite_addr_fifo.sv
// AXI-Lite address-channel receiver: queues AxADDR/AxPROT beats in a DEPTH-entry FIFO for the decoder.
// Optional per-entry misalignment flag enabled by AXILITE_ADDR_MISALIGN_CHECK_EN.
module axilite_addr_fifo #(
    parameter int ADDR_WIDTH = 32,
    parameter int PROT_WIDTH = 3,
    parameter int DEPTH      = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ADDR_WIDTH-1:0]        addr,
    input  logic [PROT_WIDTH-1:0]        prot,
    input  logic                         valid,
    output logic                         ready,
    input  logic                         deassert_addr,
    output logic [ADDR_WIDTH-1:0]        held_addr,
    output logic [PROT_WIDTH-1:0]        held_prot,
    output logic                         held_misaligned,
    output logic                         addr_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_WIDTH-1:0] addr_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem_d [DEPTH];
    logic [PROT_WIDTH-1:0] prot_mem_q [DEPTH];
    logic [PROT_WIDTH-1:0] prot_mem_d [DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ready_q, ready_d;
    logic                  push;
    logic                  pop;

    // ready is registered so it stays low through reset and has no path from valid
    assign push = valid && ready_q;
    assign pop  = deassert_addr && (count_q != '0);

    always_comb begin
        addr_mem_d = addr_mem_q;
        prot_mem_d = prot_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        count_d    = count_q;
        if (push) begin
            addr_mem_d[wptr_q] = addr;
            prot_mem_d[wptr_q] = prot;
            wptr_d             = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        ready_d = (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_q[i] <= '0;
                prot_mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            addr_mem_q <= addr_mem_d;
            prot_mem_q <= prot_mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
        end
    end

`ifdef AXILITE_ADDR_MISALIGN_CHECK_EN
    logic mis_mem_q [DEPTH];
    logic mis_mem_d [DEPTH];

    always_comb begin
        mis_mem_d = mis_mem_q;
        if (push) begin
            mis_mem_d[wptr_q] = (addr[1:0] != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mis_mem_q[i] <= 1'b0;
            end
        end else begin
            mis_mem_q <= mis_mem_d;
        end
    end

    assign held_misaligned = addr_ready ? mis_mem_q[rptr_q] : 1'b0;
`else
    assign held_misaligned = 1'b0;
`endif

    assign addr_ready = (count_q != '0);
    assign ready      = ready_q;
    assign count      = count_q;
    assign held_addr  = addr_ready ? addr_mem_q[rptr_q] : '0;
    assign held_prot  = addr_ready ? prot_mem_q[rptr_q] : '0;

endmodule

// File: tb/tb_axilite_addr_fifo.sv
// Scoreboard bench for axilite_addr_fifo: expected beats queued at push, compared at pop.
module tb_axilite_addr_fifo;

    localparam int AW = 32;
    localparam int PRW = 3;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH+1);

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic [PRW-1:0] prot = '0;
    logic           valid = 1'b0;
    logic           ready;
    logic           deassert_addr = 1'b0;
    logic [AW-1:0]  held_addr;
    logic [PRW-1:0] held_prot;
    logic           held_misaligned;
    logic           addr_ready;
    logic [CW-1:0]  count;

    typedef struct {
        logic [AW-1:0]  a;
        logic [PRW-1:0] p;
        logic           m;
    } beat_t;

    beat_t sb[$];
    int    m_count = 0;
    logic  exp_ready = 1'b0;
    int    n_checks = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    axilite_addr_fifo #(.ADDR_WIDTH(AW), .PROT_WIDTH(PRW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .prot(prot), .valid(valid), .ready(ready),
        .deassert_addr(deassert_addr), .held_addr(held_addr), .held_prot(held_prot),
        .held_misaligned(held_misaligned), .addr_ready(addr_ready), .count(count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_mis(input logic [AW-1:0] a);
`ifdef AXILITE_ADDR_MISALIGN_CHECK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive inputs, check pre-edge outputs, update model, check count
    task automatic cycle(input logic v, input logic [AW-1:0] a, input logic [PRW-1:0] p, input logic pop_req);
        logic  acc, deq;
        beat_t e;
        valid = v; addr = a; prot = p; deassert_addr = pop_req;
        #1;
        check("ready", {63'd0, ready}, {63'd0, exp_ready});
        check("addr_ready", {63'd0, addr_ready}, {63'd0, m_count != 0});
        if (m_count == 0) begin
            check("held_addr_empty", {32'd0, held_addr}, 64'd0);
            check("held_mis_empty", {63'd0, held_misaligned}, 64'd0);
        end
        deq = pop_req && (m_count != 0);
        acc = v && exp_ready;
        if (deq) begin
            e = sb.pop_front();
            check("held_addr", {32'd0, held_addr}, {32'd0, e.a});
            check("held_prot", {61'd0, held_prot}, {61'd0, e.p});
            check("held_mis", {63'd0, held_misaligned}, {63'd0, e.m});
        end
        if (acc) sb.push_back('{a: a, p: p, m: exp_mis(a)});
        @(posedge clk); #1;
        m_count = m_count + int'(acc) - int'(deq);
        exp_ready = (m_count != DEPTH);
        check("count", {{(64-CW){1'b0}}, count}, 64'(m_count));
    endtask

    initial begin
        // reset with a beat presented: nothing accepted
        rst_n = 1'b0; valid = 1'b1; addr = 32'h10;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_count", {{(64-CW){1'b0}}, count}, 64'd0);
        check("rst_addr_ready", {63'd0, addr_ready}, 64'd0);
        check("rst_held_addr", {32'd0, held_addr}, 64'd0);
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 3'd0, 1'b0);
        check("ready_after_rst", {63'd0, ready}, 64'd1);

        // fill, then hold a fifth beat that must not be taken
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 3'(i), 1'b0);
        check("full_head", {32'd0, held_addr}, 64'h0);
        cycle(1'b1, 32'h10, 3'd0, 1'b0);
        cycle(1'b1, 32'h10, 3'd0, 1'b0);
        check("full_ready", {63'd0, ready}, 64'd0);

        // drain, then a pop on empty
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 3'd0, 1'b1);
        cycle(1'b0, 32'h0, 3'd0, 1'b1);
        check("drain_count", {{(64-CW){1'b0}}, count}, 64'd0);

        // concurrent streaming, occupancy stays at one
        cycle(1'b1, 32'h100, 3'b010, 1'b0);
        for (int i = 1; i < 10; i++) begin
            cycle(1'b1, 32'h100 + 32'(i * 4), 3'b010, 1'b1);
            check("stream_count", {{(64-CW){1'b0}}, count}, 64'd1);
        end
        cycle(1'b0, 32'h0, 3'd0, 1'b1);
        check("stream_sb_empty", 64'(sb.size()), 64'd0);

        // full with simultaneous pop: pop only, then held beat accepted
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h200 + 32'(i * 4), 3'(i + 1), 1'b0);
        cycle(1'b1, 32'h300, 3'd5, 1'b1);
        check("full_pop_count", {{(64-CW){1'b0}}, count}, 64'd3);
        cycle(1'b1, 32'h300, 3'd5, 1'b0);
        check("full_refill_count", {{(64-CW){1'b0}}, count}, 64'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 3'd0, 1'b1);

        // misalignment flag, then asynchronous flush with two entries queued
        cycle(1'b1, 32'h13, 3'd1, 1'b0);
        check("mis_13", {63'd0, held_misaligned}, {63'd0, exp_mis(32'h13)});
        cycle(1'b1, 32'h14, 3'd1, 1'b0);
        cycle(1'b0, 32'h0, 3'd0, 1'b1);
        check("mis_14", {63'd0, held_misaligned}, 64'd0);
        check("head_14", {32'd0, held_addr}, 64'h14);
        cycle(1'b1, 32'h18, 3'd2, 1'b0);
        check("pre_flush_count", {{(64-CW){1'b0}}, count}, 64'd2);
        valid = 1'b0; deassert_addr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("flush_count", {{(64-CW){1'b0}}, count}, 64'd0);
        check("flush_addr_ready", {63'd0, addr_ready}, 64'd0);
        check("flush_held_addr", {32'd0, held_addr}, 64'd0);
        check("flush_ready", {63'd0, ready}, 64'd0);
        sb.delete();
        m_count = 0;
        exp_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(1'b0, 32'h0, 3'd0, 1'b0);
        cycle(1'b1, 32'h40, 3'd7, 1'b0);
        cycle(1'b0, 32'h0, 3'd0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/axilite_addr_fifo.md
# axilite_addr_fifo

Buffered AXI-Lite address-channel receiver: accepts AxADDR/AxPROT beats on a valid/ready handshake and queues them in a DEPTH-entry FIFO for the downstream register/command decoder. The decoder reads the head entry and pops it with `deassert_addr`. Several addresses can therefore be outstanding while the decoder is still busy. It sits between the AXI-Lite slave port (AW or AR channel, one instance each) and the coprocessor's transaction sequencer.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width in bits
- `PROT_WIDTH`, 3, AxPROT width (0 not allowed)
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `addr`  in  ADDR_WIDTH  AxADDR from the AXI-Lite master
- `prot`  in  PROT_WIDTH  AxPROT from the AXI-Lite master
- `valid`  in  1  AxVALID
- `ready`  out  1  AxREADY
- `deassert_addr`  in  1  pop request from the consumer
- `held_addr`  out  ADDR_WIDTH  head-entry address
- `held_prot`  out  PROT_WIDTH  head-entry prot
- `held_misaligned`  out  1  head entry has `addr[1:0] != 0` (see Configuration)
- `addr_ready`  out  1  FIFO non-empty; head outputs are valid
- `count`  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH

## Operation
- **Storage:** circular buffer with write pointer `wptr`, read pointer `rptr` (each log2(DEPTH) bits, wrap modulo DEPTH) and a registered occupancy `count`.
- **Push condition:** `valid && ready`. The entry {addr, prot[, misaligned]} is written at `wptr`, then `wptr` increments.
- **`ready`:** `count != DEPTH`, decoded from registered state only. There is no combinational path from `valid` to `ready`.
- **Pop condition:** `deassert_addr && addr_ready`, then `rptr` increments. `deassert_addr` while empty is ignored, with no pointer or count change.
- **Simultaneous push and pop:** both occur and `count` is unchanged. When full, no push can occur because `ready`=0, so only the pop takes effect.
- **`addr_ready`:** `count != 0`.
- **Head outputs:** `held_addr`, `held_prot` and `held_misaligned` show the entry at `rptr` when `addr_ready`=1, and are forced to 0 when empty.
- **Ordering:** strictly FIFO. No entry is dropped or duplicated.
- **Mid-operation reset:** asserting `rst_n` low flushes all entries asynchronously and ends any transfer in progress.

## Timing
- **Reset values:** while `rst_n`=0, `ready`=0, `addr_ready`=0, `count`=0, `held_*`=0, pointers=0, storage=0. `ready` rises on the first rising edge after `rst_n` deasserts.
- **Latency:** a beat accepted at edge N appears on `held_*`, with `addr_ready`=1, after edge N if the FIFO was empty. There is no same-cycle bypass.
- **Pop timing:** a pop at edge N presents the next entry, or `addr_ready`=0, after edge N.
- **`ready` after pop when full:** `ready` returns to 1 in the cycle after a pop from full.
- **Throughput:** one push and one pop per cycle sustained.
- **`count` update:** +1 on push only, −1 on pop only, unchanged on both or neither.

## Configuration
- **Macro:** `AXILITE_ADDR_MISALIGN_CHECK_EN`.
- **Defined:** each entry stores an extra bit equal to `addr[1:0] != 0`, captured at push. `held_misaligned` reflects the head entry's bit and is 0 when empty. The consumer uses it to return SLVERR.
- **Undefined:** no extra storage bit exists and `held_misaligned` is tied to 0.

## Test plan
- **Reset:** with `rst_n`=0, drive `valid`=1, `addr`=0x10 → `ready`=0, `count`=0 and no push occurs. After release, `ready`=1 on the first edge.
- **Fill and overflow (DEPTH=4):** push 0x00, 0x04, 0x08, 0x0C back-to-back with no pops → `count`=4, `ready`=0, `held_addr`=0x00. Hold a fifth `valid` with `addr`=0x10 → it is not accepted.
- **Drain:** pop four times → `held_addr` reads 0x00, 0x04, 0x08, 0x0C in order, then `addr_ready`=0 and `held_addr`=0. A further `deassert_addr` leaves `count`=0.
- **Concurrent streaming:** push and pop every cycle for 10 beats, 0x100 to 0x124 step 4, with `prot`=3'b010 → `count` stays 1, pointers wrap, and the pop sequence matches the push sequence exactly.
- **Full with simultaneous pop:** at `count`=4 with `valid`=1 and `deassert_addr`=1 → only the pop occurs and `count`=3. The held beat is accepted on the next edge, bringing `count` back to 4.
- **Misalignment and mid-stream reset (macro defined):** push 0x13 → `held_misaligned`=1; push 0x14 → 0 when it reaches the head. Then assert `rst_n` low with 2 entries queued → asynchronous flush, `count`=0 and `addr_ready`=0 immediately.
